// File: rtl/seg_counter_pkg.sv
// Shared types, defaults and helpers for the segmented up/down counter with lowest-set-bit match.
package seg_counter_pkg;

  localparam int DEF_DIG_W  = 4;
  localparam int DEF_DIGITS = 4;
  // Widest counter lsb_onehot can serve; callers zero-extend into it.
  localparam int LSB_MAX_W  = 64;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  // Two's-complement trick isolates the lowest set bit; zero input gives zero.
  function automatic logic [LSB_MAX_W-1:0] lsb_onehot(input logic [LSB_MAX_W-1:0] vec);
    return vec & (~vec + LSB_MAX_W'(1));
  endfunction

endpackage

// File: rtl/seg_digit.sv
// One counter digit: next value and carry/borrow out, given carry/borrow in and direction.
// Purely combinational; the state register lives in the top level.
import seg_counter_pkg::*;

module seg_digit #(
  parameter int DIG_W = DEF_DIG_W
) (
  input  logic [DIG_W-1:0] i_dig,
  input  dir_e             i_dir,
  input  logic             i_cin,
  output logic [DIG_W-1:0] o_nxt,
  output logic             o_cout
);

  logic w_term;

  // Terminal state: all ones when counting up, all zeros when counting down.
  assign w_term = (i_dir == DIR_UP) ? (&i_dig) : (~|i_dig);
  assign o_cout = i_cin & w_term;

  always_comb begin
    o_nxt = i_dig;
    if (i_cin) begin
      o_nxt = (i_dir == DIR_UP) ? (i_dig + DIG_W'(1)) : (i_dig - DIG_W'(1));
    end
  end

endmodule

// File: rtl/seg_counter_match.sv
// Segmented up/down counter with load, wrap/saturate, terminal count and lowest-set-bit match Z.
// Z_REG_EN defined: Z is registered (one cycle behind the match); otherwise Z is combinational.
import seg_counter_pkg::*;

module seg_counter_match #(
  parameter int DIG_W    = DEF_DIG_W,
  parameter int DIGITS   = DEF_DIGITS,
  parameter int SATURATE = 0,
  localparam int N       = DIG_W * DIGITS
) (
  input  logic         i_ck,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_up,
  input  logic         i_ld,
  input  logic [N-1:0] i_ld_val,
  input  logic [N:0]   i_c,
  output logic [N-1:0] o_q,
  output logic         o_tc,
  output logic         o_z
);

  logic [N-1:0]    r_q;
  logic [N-1:0]    w_q_nxt;
  logic [N-1:0]    w_sel;
  logic [DIGITS:0] w_carry;
  logic            w_z_comb;
  logic            w_hold;
  dir_e            w_dir;

  assign w_dir      = dir_e'(i_up);
  assign w_carry[0] = i_en;

  // Each digit only steps when every lower digit sits at its terminal state.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg_digit #(
      .DIG_W (DIG_W)
    ) u_digit (
      .i_dig  (r_q[g*DIG_W +: DIG_W]),
      .i_dir  (w_dir),
      .i_cin  (w_carry[g]),
      .o_nxt  (w_q_nxt[g*DIG_W +: DIG_W]),
      .o_cout (w_carry[g+1])
    );
  end

  // Carry out of the top digit is exactly EN & (all-ones up / all-zeros down).
  assign o_tc   = w_carry[DIGITS];
  assign w_hold = (SATURATE != 0) && o_tc;

  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_ld_val;
    end else if (!w_hold) begin
      r_q <= w_q_nxt;
    end
  end

  assign o_q      = r_q;
  assign w_sel    = N'(lsb_onehot(LSB_MAX_W'(r_q))) & {N{i_en}};
  assign w_z_comb = (i_en & i_c[0]) | (|(i_c[N:1] & w_sel));

`ifdef Z_REG_EN
  logic r_z;

  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_z <= 1'b0;
    end else begin
      r_z <= w_z_comb;
    end
  end

  assign o_z = r_z;
`else
  assign o_z = w_z_comb;
`endif

endmodule

// File: tb/tb_seg_counter_match.sv
// Directed and random checks of seg_counter_match, wrap and saturate builds side by side.
module tb_seg_counter_match;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst, en, up, ld;
  logic [N-1:0]  ld_val;
  logic [N:0]    c;
  logic [N-1:0]  q_w, q_s;
  logic          tc_w, tc_s, z_w, z_s;

  logic [N-1:0]  m_q_w, m_q_s;
  logic          m_zr_w, m_zr_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_counter_match #(.DIG_W(4), .DIGITS(4), .SATURATE(0)) u_dut_wrap (
    .i_ck(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_ld(ld), .i_ld_val(ld_val),
    .i_c(c), .o_q(q_w), .o_tc(tc_w), .o_z(z_w)
  );

  seg_counter_match #(.DIG_W(4), .DIGITS(4), .SATURATE(1)) u_dut_sat (
    .i_ck(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_ld(ld), .i_ld_val(ld_val),
    .i_c(c), .o_q(q_s), .o_tc(tc_s), .o_z(z_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_tc(input logic [N-1:0] q);
    return en & (up ? (q == 16'hFFFF) : (q == 16'h0000));
  endfunction

  // Scan for the lowest set bit and pair it with its mask bit.
  function automatic logic model_z(input logic [N-1:0] q);
    logic r;
    r = en & c[0];
    for (int k = 1; k <= N; k++) begin
      if (q[k-1]) begin
        r = r | (en & c[k]);
        break;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] model_next(input logic [N-1:0] q, input logic sat);
    if (rst) return '0;
    if (ld)  return ld_val;
    if (!en) return q;
    if (up) begin
      if (sat && q == 16'hFFFF) return q;
      return q + 16'd1;
    end
    if (sat && q == 16'h0000) return q;
    return q - 16'd1;
  endfunction

  // One clock: check same-cycle outputs, advance the model, check the new count.
  task automatic cycle(input bit pre_chk);
    logic zc_w, zc_s;
    #1;
    zc_w = model_z(m_q_w);
    zc_s = model_z(m_q_s);
    if (pre_chk) begin
      chk("tc_wrap", 32'(tc_w), 32'(model_tc(m_q_w)));
      chk("tc_sat",  32'(tc_s), 32'(model_tc(m_q_s)));
`ifdef Z_REG_EN
      chk("z_wrap", 32'(z_w), 32'(m_zr_w));
      chk("z_sat",  32'(z_s), 32'(m_zr_s));
`else
      chk("z_wrap", 32'(z_w), 32'(zc_w));
      chk("z_sat",  32'(z_s), 32'(zc_s));
`endif
    end
    @(posedge clk);
    m_zr_w = rst ? 1'b0 : zc_w;
    m_zr_s = rst ? 1'b0 : zc_s;
    m_q_w  = model_next(m_q_w, 1'b0);
    m_q_s  = model_next(m_q_s, 1'b1);
    #1;
    chk("q_wrap", 32'(q_w), 32'(m_q_w));
    chk("q_sat",  32'(q_s), 32'(m_q_s));
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [N-1:0] lv, input logic [N:0] cm);
    rst = r; en = e; up = u; ld = l; ld_val = lv; c = cm;
  endtask

  initial begin
    m_q_w = '0; m_q_s = '0; m_zr_w = 1'b0; m_zr_s = 1'b0;
    drive(1, 0, 1, 0, '0, '0);
    @(posedge clk); #1;

    // Reset for two cycles, then idle.
    cycle(0);
    cycle(0);
    drive(0, 0, 1, 0, '0, '0);
    chk("rst_q", 32'(q_w), 32'h0);
    chk("rst_tc", 32'(tc_w), 32'h0);
    chk("rst_z", 32'(z_w), 32'h0);
    cycle(1);
    cycle(1);
    chk("idle_q", 32'(q_w), 32'h0);

    // Count up with mask bit 2: Z marks counts whose lowest set bit is bit 1.
    drive(0, 1, 1, 0, '0, 17'h00004);
    for (int i = 0; i < 12; i++) cycle(1);
    chk("cnt12_q", 32'(q_w), 32'h000C);

    // Load near the top and wrap / saturate.
    drive(0, 0, 1, 1, 16'hFFFE, '0);
    cycle(1);
    chk("ld_q", 32'(q_w), 32'hFFFE);
    drive(0, 1, 1, 0, '0, '0);
    cycle(1);
    chk("up_ffff_q", 32'(q_w), 32'hFFFF);
    chk("up_ffff_tc", 32'(tc_w), 32'h1);
    cycle(1);
    chk("wrap_q", 32'(q_w), 32'h0000);
    chk("sat_q", 32'(q_s), 32'hFFFF);
    chk("sat_tc", 32'(tc_s), 32'h1);

    // Count down through zero.
    drive(0, 0, 1, 1, 16'h0001, '0);
    cycle(1);
    drive(0, 1, 0, 0, '0, '0);
    cycle(1);
    chk("dn_zero_q", 32'(q_w), 32'h0000);
    chk("dn_zero_tc", 32'(tc_w), 32'h1);
    cycle(1);
    chk("dn_wrap_q", 32'(q_w), 32'hFFFF);
    chk("dn_sat_q", 32'(q_s), 32'h0000);

    // Reset beats load and enable; load beats enable.
    drive(0, 0, 1, 1, 16'h1234, '0);
    cycle(1);
    drive(1, 1, 1, 1, 16'h5555, '0);
    cycle(1);
    chk("prio_rst_q", 32'(q_w), 32'h0000);
    drive(0, 0, 1, 1, 16'h1234, '0);
    cycle(1);
    drive(0, 1, 1, 1, 16'h5555, '0);
    cycle(1);
    chk("prio_ld_q", 32'(q_w), 32'h5555);

    // Z timing on an EN edge with only C[0] set.
    drive(1, 0, 1, 0, '0, 17'h00001);
    cycle(1);
    drive(0, 0, 1, 0, '0, 17'h00001);
    cycle(1);
    en = 1'b1;
    #1;
`ifdef Z_REG_EN
    chk("z_en_t", 32'(z_w), 32'h0);
`else
    chk("z_en_t", 32'(z_w), 32'h1);
`endif
    cycle(1);
    chk("z_en_t1", 32'(z_w), 32'h1);

    // Long random run against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 15) == 0), 16'($urandom), 17'($urandom));
      cycle(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
